// File: rtl/mp_serializer_pkg.sv
// Shared types and elaboration helpers for the multi-lane serializer.
package mp_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int beats(input int width, input int lanes);
    return width / lanes;
  endfunction

  // A single-beat word still needs a one-bit counter so the compare logic stays uniform.
  function automatic int cnt_width(input int nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

endpackage

// File: rtl/mp_lane_serializer_if.sv
// Parallel-in / lane-out bus between the datapath (master) and the serializer (slave).
interface mp_lane_serializer_if #(
  parameter int width_p = 256,
  parameter int lanes_p = 1
);

  logic [width_p-1:0] data_i;
  logic               v_i;
  logic               ready_o;
  logic [lanes_p-1:0] data_o;
  logic               v_o;
  logic               first_o;
  logic               last_o;

  modport master (
    output data_i, v_i,
    input  ready_o, data_o, v_o, first_o, last_o
  );

  modport slave (
    input  data_i, v_i,
    output ready_o, data_o, v_o, first_o, last_o
  );

endinterface

// File: rtl/mp_ser_hold_reg.sv
// One-word skid/holding register in front of the shifter; owns the upstream handshake.
module mp_ser_hold_reg #(
  parameter int width_p = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [width_p-1:0] data,
  input  logic               v,
  input  logic               load,
  output logic               ready,
  output logic [width_p-1:0] hold,
  output logic               hold_v
);

  logic hs;

  // ready only looks at registered state plus load, so it never depends on v.
  assign ready = ~hold_v | load;
  assign hs    = v & ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v <= 1'b0;
    end else if (flush) begin
      hold_v <= 1'b0;
    end else if (hs) begin
      hold_v <= 1'b1;
    end else if (load) begin
      hold_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      hold <= data;
    end
  end

endmodule

// File: rtl/mp_lane_serializer.sv
// Streams width_p-bit words out over lanes_p serial lanes, one beat per clock, gapless.
module mp_lane_serializer
  import mp_serializer_pkg::*;
#(
  parameter int width_p     = 256,
  parameter int lanes_p     = 1,
  parameter bit msb_first_p = 1'b0,
  parameter bit idle_val_p  = 1'b0
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic flush_i,
  mp_lane_serializer_if.slave bus
);

  localparam int BEATS = beats(width_p, lanes_p);
  localparam int CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_SHIFT = SHIFT;

  logic [width_p-1:0] hold;
  logic               hold_v;
  logic               ready;
  logic               load;
  logic [0:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               last_beat;
  logic               shifting;
  logic [width_p-1:0] sreg;
  logic [width_p-1:0] sreg_next;
  logic [lanes_p-1:0] slice;

  mp_ser_hold_reg #(
    .width_p (width_p)
  ) u_hold (
    .clk    (clk_i),
    .rst_n  (reset_n_i),
    .flush  (flush_i),
    .data   (bus.data_i),
    .v      (bus.v_i),
    .load   (load),
    .ready  (ready),
    .hold   (hold),
    .hold_v (hold_v)
  );

  assign shifting  = (state == ST_SHIFT);
  assign last_beat = (cnt == LAST_CNT);
  assign load      = hold_v & ((state == ST_IDLE) | last_beat) & ~flush_i;

  // The current beat always sits at the outgoing end of the shift register.
  assign slice     = msb_first_p ? sreg[width_p-1 -: lanes_p] : sreg[lanes_p-1:0];
  assign sreg_next = msb_first_p ? (sreg << lanes_p) : (sreg >> lanes_p);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else if (flush_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (load) begin
      state <= ST_SHIFT;
      cnt   <= '0;
      sreg  <= hold;
    end else if (shifting) begin
      if (last_beat) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        cnt   <= cnt + 1'b1;
        sreg  <= sreg_next;
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.v_o     = shifting;
  assign bus.data_o  = shifting ? slice : {lanes_p{idle_val_p}};
  assign bus.first_o = shifting & (cnt == '0);
  assign bus.last_o  = shifting & last_beat;

endmodule

// File: tb/tb_mp_lane_serializer.sv
// Scoreboard bench for mp_lane_serializer across four lane/order configurations.
module tb_mp_lane_serializer;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;

  always #5 clk = ~clk;

  mp_lane_serializer_if #(.width_p(8), .lanes_p(2)) ifa ();
  mp_lane_serializer_if #(.width_p(8), .lanes_p(2)) ifb ();
  mp_lane_serializer_if #(.width_p(4), .lanes_p(4)) ifc ();
  mp_lane_serializer_if #(.width_p(8), .lanes_p(1)) ifd ();

  mp_lane_serializer #(.width_p(8), .lanes_p(2), .msb_first_p(1'b0), .idle_val_p(1'b0)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .bus(ifa));
  mp_lane_serializer #(.width_p(8), .lanes_p(2), .msb_first_p(1'b1), .idle_val_p(1'b0)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .bus(ifb));
  mp_lane_serializer #(.width_p(4), .lanes_p(4), .msb_first_p(1'b0), .idle_val_p(1'b0)) dut_c (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .bus(ifc));
  mp_lane_serializer #(.width_p(8), .lanes_p(1), .msb_first_p(1'b0), .idle_val_p(1'b0)) dut_d (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .bus(ifd));

  typedef struct packed {
    logic [3:0] d;
    logic       f;
    logic       l;
  } exp_t;

  typedef struct {
    logic [7:0] word;
    logic [1:0] lsb [4];
    logic [1:0] msb [4];
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t qd[$];
  vec_t tab[6];
  int   errs   = 0;
  int   chks   = 0;
  int   cyc    = 0;
  int   d_pops = 0;
  int   hc[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic extra(input string name, input logic [31:0] act);
    chks++;
    errs++;
    $display("FAIL %s: v_o high with no word outstanding, data 0x%0h", name, act);
  endtask

  task automatic mon();
    exp_t e;
    if (reset_n && ifa.v_o) begin
      if (qa.size() == 0) extra("a_extra_beat", 32'(ifa.data_o));
      else begin
        e = qa.pop_front();
        chk("a_data",  32'(ifa.data_o),  32'(e.d[1:0]));
        chk("a_first", 32'(ifa.first_o), 32'(e.f));
        chk("a_last",  32'(ifa.last_o),  32'(e.l));
      end
    end
    if (reset_n && ifb.v_o) begin
      if (qb.size() == 0) extra("b_extra_beat", 32'(ifb.data_o));
      else begin
        e = qb.pop_front();
        chk("b_data",  32'(ifb.data_o),  32'(e.d[1:0]));
        chk("b_first", 32'(ifb.first_o), 32'(e.f));
        chk("b_last",  32'(ifb.last_o),  32'(e.l));
      end
    end
    if (reset_n && ifc.v_o) begin
      if (qc.size() == 0) extra("c_extra_beat", 32'(ifc.data_o));
      else begin
        e = qc.pop_front();
        chk("c_data",  32'(ifc.data_o),  32'(e.d));
        chk("c_first", 32'(ifc.first_o), 32'(e.f));
        chk("c_last",  32'(ifc.last_o),  32'(e.l));
      end
    end
    if (reset_n && ifd.v_o) begin
      if (qd.size() == 0) extra("d_extra_beat", 32'(ifd.data_o));
      else begin
        e = qd.pop_front();
        d_pops++;
        chk("d_bit",   32'(ifd.data_o),  32'(e.d[0]));
        chk("d_first", 32'(ifd.first_o), 32'(e.f));
        chk("d_last",  32'(ifd.last_o),  32'(e.l));
      end
    end
  endtask

  // Outputs are compared on the falling edge; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return ifa.ready_o;
      1:       return ifc.ready_o;
      default: return ifd.ready_o;
    endcase
  endfunction

  task automatic wait_rdy(input int sel);
    int n = 0;
    while (!rdy(sel) && n < 64) begin
      tick();
      n++;
    end
    if (!rdy(sel)) begin
      chks++;
      errs++;
      $display("FAIL ready_timeout: ready_o low for %0d cycles on bus %0d, expected 1", n, sel);
    end
  endtask

  task automatic send_ab(input vec_t v);
    ifa.v_i = 1'b1; ifa.data_i = v.word;
    ifb.v_i = 1'b1; ifb.data_i = v.word;
    wait_rdy(0);
    for (int k = 0; k < 4; k++) begin
      qa.push_back('{d: 4'(v.lsb[k]), f: (k == 0), l: (k == 3)});
      qb.push_back('{d: 4'(v.msb[k]), f: (k == 0), l: (k == 3)});
    end
    tick();
  endtask

  task automatic send_c(input logic [3:0] w);
    ifc.v_i = 1'b1; ifc.data_i = w;
    wait_rdy(1);
    qc.push_back('{d: w, f: 1'b1, l: 1'b1});
    tick();
  endtask

  task automatic send_d(input logic [7:0] w, output int hs_cyc);
    ifd.v_i = 1'b1; ifd.data_i = w;
    wait_rdy(2);
    hs_cyc = cyc;
    for (int k = 0; k < 8; k++) qd.push_back('{d: 4'(w[k]), f: (k == 0), l: (k == 7)});
    tick();
  endtask

  task automatic stop_ab();
    ifa.v_i = 1'b0;
    ifb.v_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() + qb.size() + qc.size() + qd.size()) != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(qa.size() + qb.size() + qc.size() + qd.size()), 32'd0);
  endtask

  initial begin
    ifa.v_i = 1'b0; ifa.data_i = '0;
    ifb.v_i = 1'b0; ifb.data_i = '0;
    ifc.v_i = 1'b0; ifc.data_i = '0;
    ifd.v_i = 1'b0; ifd.data_i = '0;

    tab[0] = '{word: 8'hB4, lsb: '{2'd0, 2'd1, 2'd3, 2'd2}, msb: '{2'd2, 2'd3, 2'd1, 2'd0}};
    tab[1] = '{word: 8'h5A, lsb: '{2'd2, 2'd2, 2'd1, 2'd1}, msb: '{2'd1, 2'd1, 2'd2, 2'd2}};
    tab[2] = '{word: 8'hFF, lsb: '{2'd3, 2'd3, 2'd3, 2'd3}, msb: '{2'd3, 2'd3, 2'd3, 2'd3}};
    tab[3] = '{word: 8'h00, lsb: '{2'd0, 2'd0, 2'd0, 2'd0}, msb: '{2'd0, 2'd0, 2'd0, 2'd0}};
    tab[4] = '{word: 8'h93, lsb: '{2'd3, 2'd0, 2'd1, 2'd2}, msb: '{2'd2, 2'd1, 2'd0, 2'd3}};
    tab[5] = '{word: 8'h6C, lsb: '{2'd0, 2'd3, 2'd2, 2'd1}, msb: '{2'd1, 2'd2, 2'd3, 2'd0}};

    // Reset state
    #12;
    chk("rst_v_o",   32'(ifa.v_o),     32'd0);
    chk("rst_data",  32'(ifa.data_o),  32'd0);
    chk("rst_first", 32'(ifa.first_o), 32'd0);
    chk("rst_last",  32'(ifa.last_o),  32'd0);
    chk("rst_ready", 32'(ifa.ready_o), 32'd1);
    chk("rst_ready_d", 32'(ifd.ready_o), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word, latency and return to idle
    send_ab(tab[0]);
    stop_ab();
    chk("lat_early", 32'(ifa.v_o), 32'd0);
    tick();
    chk("lat_v",     32'(ifa.v_o),     32'd1);
    chk("lat_first", 32'(ifa.first_o), 32'd1);
    repeat (4) tick();
    chk("idle_v_a",    32'(ifa.v_o),    32'd0);
    chk("idle_data_a", 32'(ifa.data_o), 32'd0);
    chk("idle_v_b",    32'(ifb.v_o),    32'd0);
    chk("idle_data_b", 32'(ifb.data_o), 32'd0);
    chk("sb_empty",    32'(qa.size() + qb.size()), 32'd0);

    // Back-to-back B4 then 5A: eight contiguous beats
    send_ab(tab[0]);
    send_ab(tab[1]);
    stop_ab();
    for (int k = 0; k < 8; k++) begin
      chk("b2b_v",     32'(ifa.v_o),     32'd1);
      chk("b2b_ready", 32'(ifa.ready_o), 32'(k >= 3));
      tick();
    end
    chk("b2b_end", 32'(ifa.v_o), 32'd0);

    // Remaining table entries as one stream
    for (int i = 2; i < 6; i++) send_ab(tab[i]);
    stop_ab();
    drain();

    // Single-beat words: one per cycle, each first and last
    send_c(4'h1);
    send_c(4'h2);
    chk("c_cont1", 32'(ifc.v_o), 32'd1);
    send_c(4'h3);
    chk("c_cont2", 32'(ifc.v_o), 32'd1);
    ifc.v_i = 1'b0;
    tick();
    chk("c_cont3", 32'(ifc.v_o), 32'd1);
    tick();
    chk("c_idle", 32'(ifc.v_o), 32'd0);

    // Backpressure on one lane: ready once every eight cycles
    for (int i = 0; i < 8; i++) send_d(8'($urandom), hc[i]);
    ifd.v_i = 1'b0;
    chk("d_gap_1", 32'(hc[1] - hc[0]), 32'd1);
    for (int i = 2; i < 8; i++) chk("d_ready_period", 32'(hc[i] - hc[i-1]), 32'd8);
    drain();
    chk("d_bits", 32'(d_pops), 32'd64);

    // Flush during beat 1 with the holding register full
    send_ab(tab[0]);
    send_ab(tab[1]);
    stop_ab();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    qa.delete();
    qb.delete();
    chk("fl_v",     32'(ifa.v_o),     32'd0);
    chk("fl_v_b",   32'(ifb.v_o),     32'd0);
    chk("fl_ready", 32'(ifa.ready_o), 32'd1);
    ifa.v_i = 1'b1; ifa.data_i = 8'hFF;
    ifb.v_i = 1'b1; ifb.data_i = 8'hFF;
    flush = 1'b1;
    chk("fl_ready_rep", 32'(ifa.ready_o), 32'd1);
    tick();
    flush = 1'b0;
    stop_ab();
    for (int k = 0; k < 6; k++) begin
      chk("fl_quiet", 32'(ifa.v_o), 32'd0);
      tick();
    end
    chk("fl_ready2", 32'(ifa.ready_o), 32'd1);
    send_ab(tab[4]);
    stop_ab();
    drain();

    // Reset asserted during beat 2 with a word held
    send_ab(tab[2]);
    send_ab(tab[3]);
    stop_ab();
    tick();
    tick();
    chk("rm_pre_v", 32'(ifa.v_o), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rm_v",     32'(ifa.v_o),     32'd0);
    chk("rm_data",  32'(ifa.data_o),  32'd0);
    chk("rm_first", 32'(ifa.first_o), 32'd0);
    chk("rm_last",  32'(ifa.last_o),  32'd0);
    chk("rm_ready", 32'(ifa.ready_o), 32'd1);
    chk("rm_v_b",   32'(ifb.v_o),     32'd0);
    qa.delete();
    qb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rm_ready_after", 32'(ifa.ready_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("rm_hold_empty", 32'(ifa.v_o), 32'd0);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule

// File: doc/mp_lane_serializer.md
Name: mp_lane_serializer

Overview:
- Parametrised successor to the 256:1 tree serializer.
- Accepts width_p-bit parallel words over a valid/ready handshake and shifts each one out over lanes_p serial lanes, one beat per clk_i.
- Generalises lane count, bit order and idle value, and streams back-to-back words without gaps.
- Sits between the on-chip datapath and the pad/PHY drivers, in a single clock domain.

Parameters:
- width_p, 256: parallel word width; must be a multiple of lanes_p.
- lanes_p, 1: number of serial output lanes; 1 <= lanes_p <= width_p.
- msb_first_p, 0: 0 sends the least-significant slice first; 1 sends the most-significant slice first.
- idle_val_p, 0: 1-bit value driven on every lane while no word is being shifted.

Ports:
- clk_i  input  1  clock; one beat per rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous abort; discards the held word and the in-flight word.
- data_i  input  width_p  parallel word.
- v_i  input  1  data_i valid.
- ready_o  output  1  block can accept data_i this cycle.
- data_o  output  lanes_p  current beat.
- v_o  output  1  data_o carries a real beat.
- first_o  output  1  high on beat 0 of a word.
- last_o  output  1  high on beat BEATS-1 of a word.

Behaviour:
- BEATS = width_p/lanes_p. The beat counter is $clog2(BEATS) bits wide (minimum 1 bit).
- Reset (reset_n_i=0), asynchronous:
  - hold_v=0, state=IDLE, counter=0, shift register=0.
  - Outputs: data_o={lanes_p{idle_val_p}}, v_o=0, first_o=0, last_o=0, ready_o=1.
- Holding register:
  - A handshake (v_i & ready_o) captures data_i into hold and sets hold_v.
  - ready_o = ~hold_v | load. ready_o is combinational from registered state only and never depends on v_i.
- Load condition:
  - load = hold_v & (state==IDLE | last_beat) & ~flush_i.
  - On load: shift register <= hold, counter <= 0, state <= SHIFT.
  - hold_v clears unless a new handshake occurs in the same cycle, in which case hold is refilled.
- States:
  - IDLE: v_o=0, data_o = idle value. Moves to SHIFT on load.
  - SHIFT: v_o=1; data_o = current slice; counter increments each cycle.
    - On last_beat (counter==BEATS-1): reload if load is true; otherwise go to IDLE.
- Slice order:
  - msb_first_p=0: beat k = word[k*lanes_p +: lanes_p].
  - msb_first_p=1: beat k = word[width_p-1-k*lanes_p -: lanes_p].
  - All output bits are register-driven; no combinational path from data_i to data_o.
- first_o = SHIFT & counter==0. last_o = SHIFT & last_beat.
- BEATS==1 (lanes_p==width_p): every SHIFT cycle is both first and last. With v_i held high, a new word is emitted every cycle.
- Latency: handshake at edge N gives beat 0 on data_o after edge N+1, provided the shifter is IDLE or on its last beat at N+1.
- Throughput: with v_i held high, words go out with no idle cycles between them (v_o stays high).
- flush_i (synchronous, higher priority than everything else):
  - Next state: hold_v=0, state=IDLE.
  - The handshake in a flush cycle is ignored; ready_o is still reported but the data is dropped.
- Reset asserted mid-word: outputs go to idle values immediately and the partial word is lost. There is no resumption after reset.
- Simultaneous last_beat, load and new handshake: all three take effect in the same cycle with no loss and no duplicate.

Decomposition:
- mp_serializer_pkg holds:
  - state_e {IDLE, SHIFT};
  - the function beats(width, lanes);
  - the function slice_sel(word, k, msb_first) if shared.
- One sub-module, mp_ser_hold_reg: the width_p holding register with its valid bit and ready/handshake logic (async active-low reset, flush).
- The shifter, counter and FSM stay in the top module.

Test Plan:
- Config: width_p=8, lanes_p=2, msb_first_p=0. One word 8'hB4 -> data_o = 00, 01, 11, 10 on 4 consecutive cycles; first_o on the 1st beat, last_o on the 4th; then v_o=0 and data_o=00.
- Same word with msb_first_p=1 -> beats 10, 11, 01, 00.
- Back-to-back: v_i held high with 8'hB4 then 8'h5A -> 8 contiguous v_o=1 beats: 00 01 11 10 10 10 01 01. No gap; ready_o drops only while hold_v=1 and there is no load.
- width_p=lanes_p=4, stream 4'h1, 4'h2, 4'h3 -> data_o 1, 2, 3 on consecutive cycles; first_o=last_o=1 on each.
- Mid-word events: reset_n_i low during beat 2 -> outputs idle in the same cycle, hold empty after release. flush_i during beat 1 with hold full -> IDLE next cycle, held word never appears.
- Backpressure: v_i high continuously, width_p=8, lanes_p=1 -> ready_o high for exactly 1 cycle in every 8; no word dropped; 64 bits out over 8 words, matching the scoreboard.
